// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-memory request path: words, RAM status and
// arbiter state encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    StIdle,
    StDgrant,
    StIgrant,
    StError
  } arb_state_t;

  localparam int unsigned TimeoutWidth = 8;

endpackage

// File: rtl/arb_timeout_counter.sv
// Per-grant watchdog: counts cycles a granted access spends waiting on the RAM
// and flags when the allowed budget is used up.
module arb_timeout_counter
  import cpu_types_pkg::*;
#(
  parameter int unsigned Limit = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TimeoutWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + TimeoutWidth'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TimeoutWidth'(Limit - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side responder: arbitrates instruction and data requests onto one RAM
// port with data priority, non-preemptive grants and a sticky timeout error.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_err
);

  arb_state_t state_q, state_d;
  ramstate_t  rs;
  logic       dreq;
  logic       cnt_clear;
  logic       cnt_en;
  logic       expired;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

  always_comb begin
    state_d  = state_q;
    iwait    = iREN;
    dwait    = dreq;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    arb_err  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dreq) begin
          state_d = StDgrant;
        end else if (iREN) begin
          state_d = StIgrant;
        end
      end

      StDgrant: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A simultaneous read and write is resolved as a write.
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        if (!dreq) begin
          state_d = StIdle;
        end else if (rs == ACCESS) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = StIdle;
        end else begin
          cnt_en = 1'b1;
          if (rs == ERROR || expired) begin
            state_d = StError;
          end
        end
      end

      StIgrant: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = StIdle;
        end else if (rs == ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = StIdle;
        end else begin
          cnt_en = 1'b1;
          if (rs == ERROR || expired) begin
            state_d = StError;
          end
        end
      end

      StError: begin
        arb_err = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The watchdog restarts for every grant, so each access gets the full budget.
  assign cnt_clear = (state_q == StIdle) || (state_d != state_q);

  arb_timeout_counter #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an ownership/age model predicts every output
// each cycle, with literal checks pinning the key scenarios.
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [1:0] RS_FREE   = 2'b00;
  localparam logic [1:0] RS_BUSY   = 2'b01;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        arb_err;

  int total = 0;
  int bad   = 0;

  // Model: who owns the RAM (0 none, 1 data, 2 instr), cycles waited, dead.
  int owner = 0;
  int age   = 0;
  bit dead  = 1'b0;

  mem_arbiter #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .iaddr   (iaddr),
    .daddr   (daddr),
    .dstore  (dstore),
    .iwait   (iwait),
    .dwait   (dwait),
    .iload   (iload),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .arb_err (arb_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%08h want 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic model_compare();
    bit gd, gi, dn, in_, dreq;
    dreq = dREN || dWEN;
    gd   = !dead && owner == 1;
    gi   = !dead && owner == 2;
    dn   = gd && dreq && ramstate == RS_ACCESS;
    in_  = gi && iREN && ramstate == RS_ACCESS;
    chk("m_ramREN", ramREN, gd ? (dREN && !dWEN) : (gi ? iREN : 1'b0));
    chk("m_ramWEN", ramWEN, gd && dWEN);
    chk("m_ramaddr", ramaddr, gd ? daddr : (gi ? iaddr : 32'h0));
    chk("m_ramstore", ramstore, gd ? dstore : 32'h0);
    chk("m_dload", dload, dn ? ramload : 32'h0);
    chk("m_iload", iload, in_ ? ramload : 32'h0);
    chk("m_iwait", iwait, iREN && !in_);
    chk("m_dwait", dwait, dreq && !dn);
    chk("m_arb_err", arb_err, dead);
  endtask

  task automatic model_step();
    bit req;
    if (RST) begin
      owner = 0;
      age   = 0;
      dead  = 1'b0;
    end else if (!dead) begin
      if (owner == 0) begin
        owner = (dREN || dWEN) ? 1 : (iREN ? 2 : 0);
        age   = 0;
      end else begin
        req = (owner == 1) ? (dREN || dWEN) : iREN;
        if (!req || ramstate == RS_ACCESS) begin
          owner = 0;
          age   = 0;
        end else if (ramstate == RS_ERROR || age == TO - 1) begin
          dead = 1'b1;
        end else begin
          age++;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge CLK);
    model_compare();
  endtask

  task automatic adv();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_all();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = RS_FREE; ramload = 32'h0;
  endtask

  initial begin
    RST = 1; idle_all();
    iaddr = 0; daddr = 0; dstore = 0;

    // Reset state
    settle();
    chk("rst_iwait", iwait, 1'b0);
    chk("rst_dwait", dwait, 1'b0);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_arb_err", arb_err, 1'b0);
    adv(); adv();
    RST = 0;
    settle(); adv();

    // Single instruction read
    iREN = 1; iaddr = 32'h0000_0040;
    settle(); chk("ird_c0_iwait", iwait, 1'b1); adv();
    ramstate = RS_ACCESS; ramload = 32'h2001_0005;
    settle();
    chk("ird_c1_iwait", iwait, 1'b0);
    chk("ird_c1_iload", iload, 32'h2001_0005);
    chk("ird_c1_addr", ramaddr, 32'h0000_0040);
    adv();
    idle_all(); settle(); adv();

    // Simultaneous requests: data first, then instruction after one IDLE
    iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h0000_1000;
    settle(); adv();
    ramstate = RS_ACCESS; ramload = 32'h11;
    settle();
    chk("sim_daddr", ramaddr, 32'h0000_1000);
    chk("sim_dload", dload, 32'h11);
    chk("sim_iwait_held", iwait, 1'b1);
    adv();
    dREN = 0; ramstate = RS_FREE;
    settle(); chk("sim_idle_ren", ramREN, 1'b0); adv();
    ramstate = RS_ACCESS; ramload = 32'h22;
    settle();
    chk("sim_iaddr", ramaddr, 32'h44);
    chk("sim_iload", iload, 32'h22);
    adv();
    idle_all(); settle(); adv();

    // Write held off by BUSY for 3 cycles
    dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    settle(); adv();
    ramstate = RS_BUSY;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk("wr_busy_wen", ramWEN, 1'b1);
      chk("wr_busy_store", ramstore, 32'hDEAD_BEEF);
      chk("wr_busy_dwait", dwait, 1'b1);
      adv();
    end
    ramstate = RS_ACCESS;
    settle();
    chk("wr_acc_dwait", dwait, 1'b0);
    chk("wr_acc_wen", ramWEN, 1'b1);
    adv();
    idle_all(); settle(); adv();

    // No preemption of an instruction grant
    iREN = 1; iaddr = 32'h100;
    settle(); adv();
    ramstate = RS_BUSY;
    settle(); adv();
    dREN = 1; daddr = 32'h200;
    settle();
    chk("np_addr_busy", ramaddr, 32'h100);
    chk("np_dwait", dwait, 1'b1);
    adv();
    ramstate = RS_ACCESS; ramload = 32'h33;
    settle(); chk("np_iwait", iwait, 1'b0); adv();
    iREN = 0; ramstate = RS_FREE;
    settle(); chk("np_idle_ren", ramREN, 1'b0); adv();
    ramstate = RS_ACCESS; ramload = 32'h44;
    settle();
    chk("np_daddr", ramaddr, 32'h200);
    chk("np_dload", dload, 32'h44);
    adv();
    idle_all(); settle(); adv();

    // Timeout: stuck BUSY on an instruction grant
    iREN = 1;
    settle(); adv();
    ramstate = RS_BUSY;
    for (int c = 1; c <= TO; c++) begin
      settle(); chk("to_grant_ren", ramREN, 1'b1); adv();
    end
    dREN = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("to_err", arb_err, 1'b1);
      chk("to_ren", ramREN, 1'b0);
      chk("to_iwait", iwait, 1'b1);
      adv();
    end
    RST = 1; iREN = 0; dREN = 0; ramstate = RS_FREE;
    settle(); chk("to_err_in_rst", arb_err, 1'b1); adv();
    RST = 0;
    settle(); chk("to_err_cleared", arb_err, 1'b0); adv();

    // RAM reports ERROR during a data grant
    dREN = 1;
    settle(); adv();
    ramstate = RS_ERROR;
    settle(); adv();
    ramstate = RS_FREE;
    settle(); chk("rerr_err", arb_err, 1'b1); chk("rerr_ren", ramREN, 1'b0); adv();
    RST = 1; dREN = 0;
    settle(); adv();
    RST = 0;
    settle(); adv();

    // Abort: data read dropped mid-BUSY
    dREN = 1; daddr = 32'h300; ramstate = RS_BUSY;
    settle(); adv();
    settle(); chk("ab_ren_on", ramREN, 1'b1); adv();
    dREN = 0;
    settle(); chk("ab_ren_drop", ramREN, 1'b0); adv();
    settle(); chk("ab_idle_addr", ramaddr, 32'h0); adv();

    // Reset during a data grant
    dREN = 1;
    settle(); adv();
    RST = 1;
    settle(); chk("rg_ren_before", ramREN, 1'b1); adv();
    RST = 0;
    settle();
    chk("rg_ren_after", ramREN, 1'b0);
    chk("rg_err", arb_err, 1'b0);
    chk("rg_dwait", dwait, 1'b1);
    adv();
    ramstate = RS_ACCESS; ramload = 32'h55;
    settle(); chk("rg_dload", dload, 32'h55); adv();
    idle_all(); settle(); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the cache-to-memory request interface: accepts instruction reads (iREN) and data reads/writes (dREN/dWEN) from the cache block, and answers with iwait/dwait and load data.
- Arbitrates the two requesters onto a single-port RAM using a state machine.
- Data has priority and grants are non-preemptive.
- Adds a per-access timeout watchdog and a sticky error state.

Parameters:
- TIMEOUT_CYCLES, 64, cycles a granted access may wait for ramstate ACCESS before the block enters ERROR (2..255).

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction read request
- dREN  in  1  data read request
- dWEN  in  1  data write request; dREN and dWEN are never both high (protocol violation: treated as write)
- iaddr  in  32  instruction byte address
- daddr  in  32  data byte address
- dstore  in  32  data write value
- iwait  out  1  instruction request not yet complete
- dwait  out  1  data request not yet complete
- iload  out  32  instruction read data
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE/BUSY/ACCESS/ERROR
- arb_err  out  1  sticky error flag

Behaviour:
- States: IDLE, DGRANT, IGRANT, ERROR. Reset: state IDLE, timeout counter 0. All RAM controls are 0 and arb_err is 0.
- Wait outputs:
  - iwait=1 whenever iREN=1 and the instruction access is not completing this cycle; otherwise 0.
  - dwait=1 whenever (dREN|dWEN)=1 and the data access is not completing this cycle; otherwise 0.
  - Both are 0 during reset with no requests.
- IDLE: no RAM enables. On the next edge:
  - go to DGRANT if dREN|dWEN;
  - else go to IGRANT if iREN;
  - else stay in IDLE.
- DGRANT:
  - Drives ramaddr=daddr, ramREN=dREN, ramWEN=dWEN, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0 the same cycle, dload=ramload (combinational), next state IDLE.
- IGRANT:
  - Drives ramaddr=iaddr, ramREN=1, ramWEN=0.
  - When ramstate==ACCESS: iwait=0 the same cycle, iload=ramload, next state IDLE.
- Latency: minimum 2 cycles from request to wait=0 (1 arbitration cycle plus 1 RAM ACCESS cycle). Every completion is followed by one IDLE cycle before the next grant.
- Non-preemption: a data request arriving during IGRANT waits until the instruction access completes, then wins the following arbitration.
- Abort: if the granted requester drops its enable before ACCESS, RAM enables drop the same cycle and the next state is IDLE. No completion is signalled.
- Outside a completing grant: iload/dload hold 0; RAM outputs not driven by the current grant are 0.
- Timeout counter (8 bits):
  - Cleared in IDLE and on every state change.
  - Increments each cycle in a grant state while ramstate != ACCESS.
  - Counter reaching TIMEOUT_CYCLES-1, or ramstate==ERROR in a grant state, sends the next state to ERROR.
- ERROR:
  - Absorbing until RST.
  - arb_err=1, all RAM enables 0, iwait=iREN, dwait=dREN|dWEN.
- Reset mid-access: the next state is IDLE, enables drop after that edge, and the in-flight access is abandoned.

Decomposition:
- Shared package cpu_types_pkg holds:
  - word_t (32-bit);
  - ramstate_t enum (FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11);
  - arbiter state enum arb_state_t.
- One natural sub-module: arb_timeout_counter (clear, enable, limit compare, expired flag).

Test Plan:
- Single instruction read: iREN=1, iaddr=0x0000_0040; RAM returns ACCESS on the 1st grant cycle with ramload=0x2001_0005 -> iwait=1 in cycle 0, iwait=0 and iload=0x2001_0005 in cycle 1.
- Simultaneous requests: iREN=1 and dREN=1 in the same cycle, daddr=0x0000_1000 -> DGRANT first with ramaddr=0x1000; IGRANT follows after the data completion plus 1 IDLE cycle.
- Write with BUSY: dWEN=1, daddr=0x80, dstore=0xDEAD_BEEF; RAM holds BUSY for 3 cycles, then ACCESS -> ramWEN=1 and ramstore=0xDEAD_BEEF throughout; dwait falls in the ACCESS cycle (cycle 4).
- No preemption: dREN rises 1 cycle after IGRANT starts, RAM BUSY for 2 cycles -> ramaddr stays iaddr until the instruction ACCESS; data is granted afterwards.
- Timeout: TIMEOUT_CYCLES=4, iREN held, ramstate stuck at BUSY -> ERROR 4 cycles into the grant, arb_err=1, ramREN=0, iwait=1 until RST; RST clears arb_err.
- Abort and reset: dREN dropped mid-BUSY -> ramREN=0 the same cycle and state IDLE next; RST asserted during DGRANT -> enables 0 after the edge and arb_err=0.
